seq_divider: RTL and testbench

//  Multi-cycle restoring divider for MIPS DIV/DIVU. It is the inverse of the

---
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU.
// Produces one quotient bit per clock, MSB first, over LEN cycles. A final
// cycle applies the operand signs and publishes quotient (LO), remainder (HI)
// and the divide-by-zero flag. Latency is fixed at LEN+2 edges, counting the
// accepting edge.
module seq_divider #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [LEN-1:0] num_1,
  input  logic [LEN-1:0] num_2,
  output logic           busy,
  output logic           done,
  output logic [LEN-1:0] quotient,
  output logic [LEN-1:0] remainder,
  output logic           div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int             CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [LEN:0]    rem_acc;    // partial remainder, one bit wider than the divisor
  logic [LEN-1:0]  quo_acc;    // dividend bits shift out, quotient bits shift in
  logic [LEN-1:0]  dvsr;       // |num_2|
  logic [LEN-1:0]  num_1_raw;  // unmodified dividend, returned on divide by zero
  logic            neg_q;
  logic            neg_r;
  logic            zero_div;

  logic            accept;
  logic [LEN-1:0]  abs_1;
  logic [LEN-1:0]  abs_2;
  logic [LEN:0]    rem_shift;
  logic            q_bit;
  logic [LEN:0]    rem_next;
  logic [LEN-1:0]  q_fix;
  logic [LEN-1:0]  r_fix;

  assign busy   = (state != IDLE);
  assign accept = start && !busy;

  // Magnitudes are taken only for DIV; MIN stays MIN, which reads correctly as unsigned.
  assign abs_1 = (is_signed && num_1[LEN-1]) ? -num_1 : num_1;
  assign abs_2 = (is_signed && num_2[LEN-1]) ? -num_2 : num_2;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_acc[LEN-1:0], quo_acc[LEN-1]};
  assign q_bit     = (rem_shift >= {1'b0, dvsr});
  assign rem_next  = q_bit ? (rem_shift - {1'b0, dvsr}) : rem_shift;

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  assign q_fix = neg_q ? -quo_acc : quo_acc;
  assign r_fix = neg_r ? -rem_acc[LEN-1:0] : rem_acc[LEN-1:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and the iterative shift-subtract datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      rem_acc   <= '0;
      quo_acc   <= '0;
      dvsr      <= '0;
      num_1_raw <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_div  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            rem_acc   <= '0;
            quo_acc   <= abs_1;
            dvsr      <= abs_2;
            num_1_raw <= num_1;
            neg_q     <= is_signed && (num_1[LEN-1] ^ num_2[LEN-1]);
            neg_r     <= is_signed && num_1[LEN-1];
            zero_div  <= (num_2 == '0);
          end
        end
        CALC: begin
          cnt     <= cnt + 1'b1;
          rem_acc <= rem_next;
          quo_acc <= {quo_acc[LEN-2:0], q_bit};
        end
        default: ;
      endcase
    end
  end

  // Result registers and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FIX) begin
        done        <= 1'b1;
        div_by_zero <= zero_div;
        quotient    <= zero_div ? '1 : q_fix;
        remainder   <= zero_div ? num_1_raw : r_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (LEN=32).
module tb_seq_divider;

  localparam int LEN = 32;
  localparam int LAT = LEN + 2;  // edges from the accepting edge to done, inclusive

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           is_signed;
  logic [LEN-1:0] num_1;
  logic [LEN-1:0] num_2;
  logic           busy;
  logic           done;
  logic [LEN-1:0] quotient;
  logic [LEN-1:0] remainder;
  logic           div_by_zero;

  int n_cmp;
  int n_bad;

  seq_divider #(.LEN(LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .num_1       (num_1),
    .num_2       (num_2),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and start; returns #1 after the accepting edge E0.
  task automatic launch(input logic sgn, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    is_signed = sgn;
    num_1     = a;
    num_2     = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  // Step edges until done; edges counts E0 as 1. Returns #1 after the done edge.
  task automatic wait_done(input int so_far, output int edges);
    edges = so_far;
    while (!done && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Complete operation: launch, wait, check latency and results.
  task automatic run_op(input string tag, input logic sgn,
                        input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                        input logic [LEN-1:0] eq, input logic [LEN-1:0] er,
                        input logic edbz);
    int edges;
    launch(sgn, a, b);
    wait_done(1, edges);
    check({tag, " latency"}, 64'(edges), 64'(LAT));
    check({tag, " q"},   64'(quotient),    64'(eq));
    check({tag, " r"},   64'(remainder),   64'(er));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
  endtask

  initial begin
    int edges;
    int seen_done;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    num_1     = '0;
    num_2     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset q",    64'(quotient), 64'd0);
    check("reset r",    64'(remainder), 64'd0);
    check("reset dbz",  64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic unsigned and signed cases.
    run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    check("busy after done", 64'(busy), 64'd0);
    run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_op("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // Divide by zero, then a clean op clears the flag.
    run_op("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run_op("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    // Start during an op (at E5) is ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);  // E1..E4
    #1;
    is_signed = 1'b1;
    num_1     = 32'd1;
    num_2     = 32'd1;
    start     = 1'b1;
    @(posedge clk);             // E5
    #1;
    start     = 1'b0;
    check("ignored start busy", 64'(busy), 64'd1);
    wait_done(6, edges);
    check("ignored start latency", 64'(edges), 64'(LAT));
    check("ignored start q", 64'(quotient), 64'd14);
    check("ignored start r", 64'(remainder), 64'd2);

    // Start in the done cycle is accepted.
    check("b2b done seen", 64'(done), 64'd1);
    launch(1'b0, 32'd1000, 32'd33);
    check("b2b busy", 64'(busy), 64'd1);
    check("b2b done drops", 64'(done), 64'd0);
    wait_done(1, edges);
    check("b2b latency", 64'(edges), 64'(LAT));
    check("b2b q", 64'(quotient), 64'd30);
    check("b2b r", 64'(remainder), 64'd10);

    // Reset mid-operation at E10.
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    repeat (10) @(posedge clk);  // E1..E10
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort q",    64'(quotient), 64'd0);
    check("abort r",    64'(remainder), 64'd0);
    check("abort dbz",  64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1;
    end
    check("abort no done", 64'(seen_done), 64'd0);
    check("abort idle", 64'(busy), 64'd0);
    run_op("divu 1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
